ifu_idu_exe: RTL and testbench

IFU_IDU_EXE -- requirements
Module: ifu_idu_exe

---
 rtl/ifu_idu_exe_pkg.sv | 83 ++++++++
 rtl/ifu_idu_exe_if.sv | 26 ++
 rtl/ifu_idu_exe_dec.sv | 91 +++++++++
 rtl/ifu_idu_exe.sv | 109 ++++++++++
 tb/tb_ifu_idu_exe.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ifu_idu_exe_pkg.sv
// Shared RV32I decode constants, operation/format enums and the decoded-instruction bundle
// passed from ifu_idu_exe_dec to the ifu_idu_exe datapath.
package ifu_idu_exe_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef enum logic [2:0] {WB_NONE, WB_ALU, WB_IMM, WB_PC_IMM, WB_PC4} wb_sel_e;
  typedef enum logic [2:0] {NPC_SEQ, NPC_JAL, NPC_JALR, NPC_BRANCH, NPC_HOLD} npc_sel_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic        use_imm;
    logic [31:0] imm;
    wb_sel_e     wb_sel;
    npc_sel_e    npc_sel;
    logic [2:0]  br_f3;
    logic        illegal;
    logic        halt;
  } dec_t;

  function automatic alu_op_e alu_from_f3(logic [2:0] f3, logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(logic [31:0] i, imm_fmt_e fmt);
    case (fmt)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/ifu_idu_exe_if.sv
// Fetch / register-file / write-back bus of the single-cycle core; master is the core side,
// slave is the memory and register-file side.
interface ifu_idu_exe_if;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] inst_out;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] res;
  logic        illegal;
  logic        halt;

  modport master (
    output pc, inst_out, rs1, rs2, wen, rd, res, illegal, halt,
    input  inst, src1, src2
  );

  modport slave (
    input  pc, inst_out, rs1, rs2, wen, rd, res, illegal, halt,
    output inst, src1, src2
  );
endinterface

// File: rtl/ifu_idu_exe_dec.sv
// Combinational RV32I decoder. With IFU_IDU_EXE_HALT_EN defined, EBREAK requests a halt
// and holds the PC; otherwise it decodes as a plain no-op.
module ifu_idu_exe_dec
  import ifu_idu_exe_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output dec_t        dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  imm_fmt_e   fmt;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rs1_o  = inst_i[19:15];
  assign rs2_o  = inst_i[24:20];
  assign rd_o   = inst_i[11:7];

  // NOTE: every field gets a default before the case so no path leaves a value held (no latch).
  always_comb begin
    fmt             = IMM_R;
    dec_o           = '0;
    dec_o.alu_op    = ALU_ADD;
    dec_o.wb_sel    = WB_NONE;
    dec_o.npc_sel   = NPC_SEQ;
    dec_o.br_f3     = funct3;
    case (opcode)
      OPC_OP: begin
        dec_o.wb_sel  = WB_ALU;
        dec_o.alu_op  = alu_from_f3(funct3, funct7[5]);
        dec_o.illegal = !((funct7 == F7_BASE) ||
                          (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)));
      end
      OPC_OP_IMM: begin
        fmt           = IMM_I;
        dec_o.use_imm = 1'b1;
        dec_o.wb_sel  = WB_ALU;
        // Bit 30 selects SRAI only for right shifts; elsewhere it is immediate data.
        dec_o.alu_op  = alu_from_f3(funct3, (funct3 == F3_SR) && funct7[5]);
        if (funct3 == F3_SLL)     dec_o.illegal = (funct7 != F7_BASE);
        else if (funct3 == F3_SR) dec_o.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
      end
      OPC_LUI:   begin fmt = IMM_U; dec_o.wb_sel = WB_IMM;    end
      OPC_AUIPC: begin fmt = IMM_U; dec_o.wb_sel = WB_PC_IMM; end
      OPC_JAL: begin
        fmt           = IMM_J;
        dec_o.wb_sel  = WB_PC4;
        dec_o.npc_sel = NPC_JAL;
      end
      OPC_JALR: begin
        fmt           = IMM_I;
        dec_o.wb_sel  = WB_PC4;
        dec_o.npc_sel = NPC_JALR;
        dec_o.illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt           = IMM_B;
        dec_o.npc_sel = NPC_BRANCH;
        dec_o.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        fmt           = IMM_I;
        dec_o.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        fmt           = IMM_S;
        dec_o.illegal = (funct3 > 3'b010);
      end
      OPC_MISC_MEM: dec_o.illegal = (funct3 != 3'b000);
      OPC_SYSTEM: begin
        if (inst_i == INST_EBREAK) begin
`ifdef IFU_IDU_EXE_HALT_EN
          dec_o.halt    = 1'b1;
          dec_o.npc_sel = NPC_HOLD;
`endif
        end else begin
          dec_o.illegal = (inst_i != INST_ECALL);
        end
      end
      default: dec_o.illegal = 1'b1;
    endcase
    dec_o.imm = imm_gen(inst_i, fmt);
  end

endmodule

// File: rtl/ifu_idu_exe.sv
// Single-cycle RV32I fetch/decode/execute core: PC register, ALU and next-PC logic around
// ifu_idu_exe_dec. EBREAK halting is enabled by the IFU_IDU_EXE_HALT_EN macro.
module ifu_idu_exe
  import ifu_idu_exe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] inst_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            wen_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] res_o,
  output logic            illegal_o,
  output logic            halt_o
);

  dec_t        dec;
  logic [31:0] pc_q, pc_d;
  logic [31:0] op_b, alu_res, wb_val, pc_plus4, pc_imm;
  logic [4:0]  shamt;
  logic        br_taken, writes;

  ifu_idu_exe_dec u_dec (
    .inst_i (inst_i),
    .rs1_o  (rs1_o),
    .rs2_o  (rs2_o),
    .rd_o   (rd_o),
    .dec_o  (dec)
  );

  assign op_b     = dec.use_imm ? dec.imm : src2_i;
  assign shamt    = op_b[4:0];
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_imm   = pc_q + dec.imm;

  always_comb begin
    case (dec.alu_op)
      ALU_ADD:  alu_res = src1_i + op_b;
      ALU_SUB:  alu_res = src1_i - op_b;
      ALU_SLL:  alu_res = src1_i << shamt;
      ALU_SLT:  alu_res = {31'd0, $signed(src1_i) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, src1_i < op_b};
      ALU_XOR:  alu_res = src1_i ^ op_b;
      ALU_SRL:  alu_res = src1_i >> shamt;
      ALU_SRA:  alu_res = $signed(src1_i) >>> shamt;
      ALU_OR:   alu_res = src1_i | op_b;
      default:  alu_res = src1_i & op_b;
    endcase
  end

  always_comb begin
    case (dec.br_f3)
      F3_BEQ:  br_taken = (src1_i == src2_i);
      F3_BNE:  br_taken = (src1_i != src2_i);
      F3_BLT:  br_taken = ($signed(src1_i) <  $signed(src2_i));
      F3_BGE:  br_taken = ($signed(src1_i) >= $signed(src2_i));
      F3_BLTU: br_taken = (src1_i <  src2_i);
      F3_BGEU: br_taken = (src1_i >= src2_i);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (dec.wb_sel)
      WB_ALU:    wb_val = alu_res;
      WB_IMM:    wb_val = dec.imm;
      WB_PC_IMM: wb_val = pc_imm;
      WB_PC4:    wb_val = pc_plus4;
      default:   wb_val = 32'd0;
    endcase
  end

  // Reset abandons the instruction in flight, so it also suppresses write-back.
  assign writes    = (dec.wb_sel != WB_NONE) && !dec.illegal && (rd_o != 5'd0) && !rst_i;
  assign wen_o     = writes;
  assign res_o     = writes ? wb_val : 32'd0;
  assign halt_o    = dec.halt && !rst_i;
  assign illegal_o = dec.illegal;
  assign inst_o    = inst_i;
  assign pc_o      = pc_q;

  always_comb begin
    pc_d = pc_plus4;
    if (!dec.illegal) begin
      case (dec.npc_sel)
        NPC_JAL:    pc_d = pc_imm;
        NPC_JALR:   pc_d = (src1_i + dec.imm) & ~32'd1;
        NPC_BRANCH: pc_d = br_taken ? pc_imm : pc_plus4;
        NPC_HOLD:   pc_d = pc_q;
        default:    pc_d = pc_plus4;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

endmodule

// File: tb/tb_ifu_idu_exe.sv
// Directed self-checking bench for ifu_idu_exe; expectations are hand-computed RV32I results.
module tb_ifu_idu_exe;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] exp_pc;

  ifu_idu_exe_if bus ();

  ifu_idu_exe dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pc_o      (bus.pc),
    .inst_i    (bus.inst),
    .inst_o    (bus.inst_out),
    .rs1_o     (bus.rs1),
    .rs2_o     (bus.rs2),
    .src1_i    (bus.src1),
    .src2_i    (bus.src2),
    .wen_o     (bus.wen),
    .rd_o      (bus.rd),
    .res_o     (bus.res),
    .illegal_o (bus.illegal),
    .halt_o    (bus.halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic [31:0] inst, input logic [31:0] s1, input logic [31:0] s2);
    bus.inst = inst;
    bus.src1 = s1;
    bus.src2 = s2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(32'h0050_0093, 32'd0, 32'd0);
    total++; if (bus.pc !== RST_PC) begin bad++; $display("FAIL rst_pc: got %h want %h", bus.pc, RST_PC); end
    total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL rst_wen: got %b want 0", bus.wen); end
    apply(32'h0010_0073, 32'd0, 32'd0);
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL rst_halt: got %b want 0", bus.halt); end
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_pc = RST_PC;
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL release_pc: got %h want %h", bus.pc, exp_pc); end
  endtask

  task automatic test_addi();
    apply(32'h0050_0093, 32'd0, 32'd0);
    total++; if (bus.wen !== 1'b1) begin bad++; $display("FAIL addi_wen: got %b want 1", bus.wen); end
    total++; if (bus.rd !== 5'd1) begin bad++; $display("FAIL addi_rd: got %0d want 1", bus.rd); end
    total++; if (bus.res !== 32'd5) begin bad++; $display("FAIL addi_res: got %h want 5", bus.res); end
    total++; if (bus.rs1 !== 5'd0) begin bad++; $display("FAIL addi_rs1: got %0d want 0", bus.rs1); end
    total++; if (bus.inst_out !== 32'h0050_0093) begin bad++; $display("FAIL inst_o: got %h want 00500093", bus.inst_out); end
    tick();
    exp_pc = RST_PC + 32'd4;
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL addi_pc: got %h want %h", bus.pc, exp_pc); end
  endtask

  task automatic test_alu();
    logic [31:0] vi [7];
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] vr [7];
    // SUB, SRA (shift from low 5 bits of 0x24), SRL, SLT, SLTU, SRAI 4, ADDI -1
    vi = '{32'h4020_81B3, 32'h4020_D1B3, 32'h0020_D1B3, 32'h0020_A1B3, 32'h0020_B1B3, 32'h4040_D193, 32'hFFF0_8193};
    va = '{32'd3, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vb = '{32'd5, 32'h24, 32'h24, 32'd1, 32'd1, 32'd0, 32'd0};
    vr = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0, 32'hF800_0000, 32'hFFFF_FFFF};
    for (int k = 0; k < 7; k++) begin
      apply(vi[k], va[k], vb[k]);
      total++; if (bus.res !== vr[k]) begin bad++; $display("FAIL alu_res[%0d]: got %h want %h", k, bus.res, vr[k]); end
      tick();
      exp_pc = exp_pc + 32'd4;
    end
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL alu_pc: got %h want %h", bus.pc, exp_pc); end
    apply(32'h4020_81B3, 32'd0, 32'd0);
    total++; if (bus.rs2 !== 5'd2) begin bad++; $display("FAIL sub_rs2: got %0d want 2", bus.rs2); end
  endtask

  task automatic test_branch();
    apply(32'hFE20_CCE3, 32'hFFFF_FFFF, 32'd1);
    total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL blt_wen: got %b want 0", bus.wen); end
    total++; if (bus.res !== 32'd0) begin bad++; $display("FAIL blt_res: got %h want 0", bus.res); end
    tick();
    exp_pc = exp_pc - 32'd8;
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL blt_pc: got %h want %h", bus.pc, exp_pc); end
    apply(32'hFE20_ECE3, 32'hFFFF_FFFF, 32'd1);
    tick();
    exp_pc = exp_pc + 32'd4;
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL bltu_pc: got %h want %h", bus.pc, exp_pc); end
    apply(32'hFE20_DCE3, 32'hFFFF_FFFF, 32'd1);
    tick();
    exp_pc = exp_pc + 32'd4;
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL bge_pc: got %h want %h", bus.pc, exp_pc); end
  endtask

  task automatic test_jump();
    apply(32'h0000_80E7, 32'h8000_0011, 32'd0);
    total++; if (bus.res !== exp_pc + 32'd4) begin bad++; $display("FAIL jalr_res: got %h want %h", bus.res, exp_pc + 32'd4); end
    tick();
    exp_pc = 32'h8000_0010;
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL jalr_pc: got %h want %h", bus.pc, exp_pc); end
    apply(32'h0100_00EF, 32'd0, 32'd0);
    total++; if (bus.res !== 32'h8000_0014) begin bad++; $display("FAIL jal_res: got %h want 80000014", bus.res); end
    tick();
    exp_pc = 32'h8000_0020;
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL jal_pc: got %h want %h", bus.pc, exp_pc); end
    apply(32'h1234_52B7, 32'd0, 32'd0);
    total++; if (bus.res !== 32'h1234_5000) begin bad++; $display("FAIL lui_res: got %h want 12345000", bus.res); end
    apply(32'h0000_1297, 32'd0, 32'd0);
    total++; if (bus.res !== 32'h8000_1020) begin bad++; $display("FAIL auipc_res: got %h want 80001020", bus.res); end
    apply(32'h0050_0013, 32'd0, 32'd0);
    total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL rd0_wen: got %b want 0", bus.wen); end
    total++; if (bus.res !== 32'd0) begin bad++; $display("FAIL rd0_res: got %h want 0", bus.res); end
    tick();
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_system();
    apply(32'h0010_0073, 32'd0, 32'd0);
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL ebreak_illegal: got %b want 0", bus.illegal); end
`ifdef IFU_IDU_EXE_HALT_EN
    total++; if (bus.halt !== 1'b1) begin bad++; $display("FAIL ebreak_halt: got %b want 1", bus.halt); end
    tick();
`else
    total++; if (bus.halt !== 1'b0) begin bad++; $display("FAIL ebreak_halt: got %b want 0", bus.halt); end
    tick();
    exp_pc = exp_pc + 32'd4;
`endif
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL ebreak_pc: got %h want %h", bus.pc, exp_pc); end
    apply(32'hFFFF_FFFF, 32'd0, 32'd0);
    total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL ill_flag: got %b want 1", bus.illegal); end
    total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL ill_wen: got %b want 0", bus.wen); end
    tick();
    exp_pc = exp_pc + 32'd4;
    total++; if (bus.pc !== exp_pc) begin bad++; $display("FAIL ill_pc: got %h want %h", bus.pc, exp_pc); end
    apply(32'h0020_A023, 32'd7, 32'd9);
    total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL sw_wen: got %b want 0", bus.wen); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL sw_illegal: got %b want 0", bus.illegal); end
    tick();
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_reset_mid();
    apply(32'h0050_0093, 32'd0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.pc !== RST_PC) begin bad++; $display("FAIL midrst_pc: got %h want %h (from %h)", bus.pc, RST_PC, exp_pc); end
    total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL midrst_wen: got %b want 0", bus.wen); end
    total++; if (bus.res !== 32'd0) begin bad++; $display("FAIL midrst_res: got %h want 0", bus.res); end
    tick();
    total++; if (bus.pc !== RST_PC) begin bad++; $display("FAIL rsthold_pc: got %h want %h", bus.pc, RST_PC); end
    rst = 1'b0;
    #1;
    tick();
    total++; if (bus.pc !== RST_PC + 32'd4) begin bad++; $display("FAIL rstfetch_pc: got %h want %h", bus.pc, RST_PC + 32'd4); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    total    = 0;
    bad      = 0;
    exp_pc   = RST_PC;
    rst      = 1'b1;
    bus.inst = 32'h0000_0013;
    bus.src1 = 32'd0;
    bus.src2 = 32'd0;
    #2;
    test_reset();
    test_addi();
    test_alu();
    test_branch();
    test_jump();
    test_system();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
